// File: rtl/mdu_iter_if.sv
// Issue/writeback bundle between the execute stage and the iterative MDU.
// The core side drives the issue signals; the MDU drives status and writeback.
interface mdu_iter_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            kill;
  logic [2:0]      funct3;
  logic [XLEN-1:0] busA;
  logic [XLEN-1:0] busB;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      adrD;
  logic            reg_write_en;

  modport master (
    output start, kill, funct3, busA, busB, rd_in,
    input  busy, done, result, adrD, reg_write_en
  );

  modport slave (
    input  start, kill, funct3, busA, busB, rd_in,
    output busy, done, result, adrD, reg_write_en
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide: 32-step shift-add multiply, restoring divide.
// Optional MDU_FAST_SPECIAL_EN short-circuits divide-by-zero and signed overflow.
module mdu_iter #(
  parameter int XLEN = 32
) (
  input  logic      clk,
  input  logic      rst,
  mdu_iter_if.slave mdu
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_count;
  logic [2:0]      r_funct3;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_opb;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_div0;
  logic            r_busy;
  logic            r_done;
  logic            r_wen;
  logic [XLEN-1:0] r_result;
  logic [4:0]      r_adrD;

  logic            w_is_div;
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_div0;
  logic            w_ovf;
  logic [XLEN:0]   w_mul_sum;
  logic [XLEN:0]   w_div_rem;
  logic [XLEN:0]   w_div_diff;
  logic            w_div_ok;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0] w_quo;
  logic [XLEN-1:0] w_rem;
  logic [XLEN-1:0] w_final;

  // Operand decode: signed ops work on magnitudes, sign restored at the end.
  assign w_is_div   = mdu.funct3[2];
  assign w_a_signed = (mdu.funct3 inside {3'd1, 3'd2, 3'd4, 3'd6});
  assign w_b_signed = (mdu.funct3 inside {3'd1, 3'd4, 3'd6});
  assign w_a_neg    = w_a_signed & mdu.busA[XLEN-1];
  assign w_b_neg    = w_b_signed & mdu.busB[XLEN-1];
  assign w_a_mag    = w_a_neg ? -mdu.busA : mdu.busA;
  assign w_b_mag    = w_b_neg ? -mdu.busB : mdu.busB;
  assign w_div0     = w_is_div & (mdu.busB == '0);
  assign w_ovf      = w_is_div & ~mdu.funct3[0] & (mdu.busA == MIN_NEG) & (mdu.busB == '1);

  assign w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
  assign w_div_rem  = {r_hi, r_lo[XLEN-1]};
  assign w_div_diff = w_div_rem - {1'b0, r_opb};
  assign w_div_ok   = ~w_div_diff[XLEN];

  assign w_prod = r_neg_q ? -{r_hi, r_lo} : {r_hi, r_lo};
  assign w_quo  = r_div0 ? '1 : (r_neg_q ? -r_lo : r_lo);
  assign w_rem  = r_neg_r ? -r_hi : r_hi;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_final = w_prod[XLEN-1:0];
    case (r_funct3)
      3'd1, 3'd2, 3'd3: w_final = w_prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:       w_final = w_quo;
      3'd6, 3'd7:       w_final = w_rem;
      default:          w_final = w_prod[XLEN-1:0];
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_funct3 <= '0;
      r_rd     <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opb    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_wen    <= 1'b0;
      r_result <= '0;
      r_adrD   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (mdu.start && !mdu.kill) begin
            r_state  <= S_CALC;
            r_busy   <= 1'b1;
            r_count  <= '0;
            r_funct3 <= mdu.funct3;
            r_rd     <= mdu.rd_in;
            r_hi     <= '0;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_div0   <= w_div0;
            r_lo     <= w_is_div ? w_a_mag : w_b_mag;
            r_opb    <= w_is_div ? w_b_mag : w_a_mag;
`ifdef MDU_FAST_SPECIAL_EN
            // Preload the final quotient/remainder and jump the counter to its end.
            if (w_div0 || w_ovf) begin
              r_count <= CW'(XLEN);
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
              r_div0  <= 1'b0;
              r_lo    <= w_div0 ? '1 : MIN_NEG;
              r_hi    <= w_div0 ? mdu.busA : '0;
            end
`endif
          end
        end
        S_CALC: begin
          if (mdu.kill) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_count == CW'(XLEN)) begin
            // Extra edge after the last iteration applies the sign fix-up.
            r_state  <= S_DONE;
            r_done   <= 1'b1;
            r_result <= w_final;
            r_adrD   <= r_rd;
            r_wen    <= (r_rd != 5'd0);
          end else begin
            r_count <= r_count + 1'b1;
            if (r_funct3[2]) begin
              r_hi <= w_div_ok ? w_div_diff[XLEN-1:0] : w_div_rem[XLEN-1:0];
              r_lo <= {r_lo[XLEN-2:0], w_div_ok};
            end else begin
              r_hi <= w_mul_sum[XLEN:1];
              r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_wen   <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_wen   <= 1'b0;
        end
      endcase
    end
  end

  assign mdu.busy         = r_busy;
  assign mdu.done         = r_done;
  assign mdu.result       = r_result;
  assign mdu.adrD         = r_adrD;
  assign mdu.reg_write_en = r_wen;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: reference model feeds a scoreboard queue,
// popped and compared at each done pulse together with latency and status.
module tb_mdu_iter;
  localparam int XLEN = 32;
  localparam logic [31:0] MIN_NEG = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mdu_iter_if #(.XLEN(XLEN)) mdu ();
  mdu_iter #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .mdu(mdu));

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        wen;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] sa, sb_, p;
    logic        ovf;
    ovf = (a == MIN_NEG) && (b == 32'hFFFF_FFFF);
    sa  = (f3 == 3'd1 || f3 == 3'd2) ? {{32{a[31]}}, a} : {32'b0, a};
    sb_ = (f3 == 3'd1) ? {{32{b[31]}}, b} : {32'b0, b};
    p   = sa * sb_;
    case (f3)
      3'd0:    return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? MIN_NEG : 32'($signed(a) / $signed(b));
      3'd5:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6:    return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
`ifdef MDU_FAST_SPECIAL_EN
    if (f3[2] && (b == 0 || (!f3[0] && a == MIN_NEG && b == 32'hFFFF_FFFF))) return 1;
`endif
    return 33;
  endfunction

  // Drives start for one cycle; returns 1 time unit after the accepting edge E0.
  task automatic drive_start(input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] rd);
    @(negedge clk);
    mdu.start  = 1'b1;
    mdu.funct3 = f3;
    mdu.busA   = a;
    mdu.busB   = b;
    mdu.rd_in  = rd;
    @(posedge clk);
    #1 mdu.start = 1'b0;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    exp_t e;
    e.result = model(f3, a, b);
    e.rd     = rd;
    e.wen    = (rd != 5'd0);
    e.lat    = model_lat(f3, a, b);
    sb.push_back(e);
    drive_start(f3, a, b, rd);
  endtask

  // pre = edges already elapsed since E0 before this call.
  task automatic wait_done(input string tag, input int pre);
    exp_t e;
    int   n    = pre;
    bit   seen = 1'b0;
    while (n < 200 && !seen) begin
      @(posedge clk);
      #1;
      n++;
      if (mdu.done === 1'b1) seen = 1'b1;
    end
    check($sformatf("%s.done_seen", tag), 32'(seen), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (seen) begin
        check($sformatf("%s.result", tag), mdu.result, e.result);
        check($sformatf("%s.adrD", tag), 32'(mdu.adrD), 32'(e.rd));
        check($sformatf("%s.wen", tag), 32'(mdu.reg_write_en), 32'(e.wen));
        check($sformatf("%s.latency", tag), 32'(n), 32'(e.lat));
        check($sformatf("%s.busy_in_done", tag), 32'(mdu.busy), 32'd1);
        @(posedge clk);
        #1;
        check($sformatf("%s.done_fall", tag), 32'(mdu.done), 32'd0);
        check($sformatf("%s.busy_fall", tag), 32'(mdu.busy), 32'd0);
        check($sformatf("%s.result_hold", tag), mdu.result, e.result);
      end
    end
  endtask

  task automatic count_done_pulses(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (mdu.done === 1'b1) pulses++;
    end
  endtask

  initial begin
    int pulses;
    mdu.start  = 1'b0;
    mdu.kill   = 1'b0;
    mdu.funct3 = 3'd0;
    mdu.busA   = '0;
    mdu.busB   = '0;
    mdu.rd_in  = '0;

    #12;
    check("reset.busy", 32'(mdu.busy), 32'd0);
    check("reset.done", 32'(mdu.done), 32'd0);
    check("reset.wen", 32'(mdu.reg_write_en), 32'd0);
    check("reset.result", mdu.result, 32'd0);
    check("reset.adrD", 32'(mdu.adrD), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);          wait_done("mul", 0);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6);  wait_done("mulhu", 0);
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);  wait_done("mulh", 0);
    issue(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd8);          wait_done("mulhsu", 0);
    issue(3'd1, 32'h1234_5678, 32'hF000_0001, 5'd9);  wait_done("mulh_mix", 0);

    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd10);         wait_done("div", 0);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd11);         wait_done("rem", 0);
    issue(3'd5, 32'd100, 32'd7, 5'd12);               wait_done("divu", 0);
    issue(3'd7, 32'd100, 32'd7, 5'd13);               wait_done("remu", 0);
    issue(3'd5, 32'hFFFF_FFF0, 32'd3, 5'd14);         wait_done("divu_big", 0);

    issue(3'd4, 32'd123, 32'd0, 5'd15);               wait_done("div_by0", 0);
    issue(3'd6, 32'd123, 32'd0, 5'd16);               wait_done("rem_by0", 0);
    issue(3'd4, 32'hFFFF_FFFB, 32'd0, 5'd17);         wait_done("div_neg_by0", 0);
    issue(3'd6, 32'hFFFF_FFFB, 32'd0, 5'd18);         wait_done("rem_neg_by0", 0);
    issue(3'd7, 32'd55, 32'd0, 5'd19);                wait_done("remu_by0", 0);
    issue(3'd4, MIN_NEG, 32'hFFFF_FFFF, 5'd20);       wait_done("div_ovf", 0);
    issue(3'd6, MIN_NEG, 32'hFFFF_FFFF, 5'd21);       wait_done("rem_ovf", 0);

    // Kill mid-calculation: no completion pulse, busy drops on the next edge.
    drive_start(3'd0, 32'd9, 32'd9, 5'd22);
    repeat (10) @(posedge clk);
    @(negedge clk);
    mdu.kill = 1'b1;
    @(posedge clk);
    #1;
    check("kill.busy", 32'(mdu.busy), 32'd0);
    check("kill.done", 32'(mdu.done), 32'd0);
    mdu.kill = 1'b0;
    count_done_pulses(40, pulses);
    check("kill.no_done", 32'(pulses), 32'd0);

    // A second start while busy must not disturb or queue behind the first op.
    issue(3'd5, 32'd100, 32'd7, 5'd9);
    repeat (3) @(posedge clk);
    @(negedge clk);
    mdu.start  = 1'b1;
    mdu.funct3 = 3'd0;
    mdu.busA   = 32'd5;
    mdu.busB   = 32'd5;
    mdu.rd_in  = 5'd3;
    @(posedge clk);
    #1 mdu.start = 1'b0;
    wait_done("busy_ignore", 4);
    count_done_pulses(40, pulses);
    check("busy_ignore.no_extra", 32'(pulses), 32'd0);

    issue(3'd0, 32'd2, 32'd3, 5'd0);                  wait_done("rd0", 0);

    // Asynchronous reset in the middle of an operation.
    drive_start(3'd0, 32'd9, 32'd9, 5'd7);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst.busy", 32'(mdu.busy), 32'd0);
    check("arst.done", 32'(mdu.done), 32'd0);
    check("arst.result", mdu.result, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    issue(3'd0, 32'd3, 32'd4, 5'd1);                  wait_done("post_rst_mul", 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
